dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
// MEM-stage initiator for the byte-addressed, big-endian data memory (MemRead/MemWrite port,
// combinational read, posedge write of 4 bytes at adr..adr+3). Turns pipeline loads/stores of
// byte/half/word size into aligned word accesses: sign/zero-extends load lanes and performs
// sub-word stores as a 2-cycle read-modify-write, stalling the pipeline for one cycle.
// PARAMETERS
// ADDR_BITS    12  memory address bits driven on dm_adr (upper bits of addr ignored)
// CHECK_ALIGN  1   1: misaligned half/word accesses are suppressed and flagged; 0: no check
// PORTS
// clk           input   1          clock; all state on posedge
// rst           input   1          synchronous, active-high reset
// mem_rd        input   1          pipeline requests a load this cycle
// mem_wr        input   1          pipeline requests a store this cycle
// size          input   2          00 byte, 01 half, 10 word, 11 reserved (illegal)
// ld_unsigned   input   1          1: zero-extend sub-word load, 0: sign-extend
// addr          input   32         byte address of the access
// wdata         input   32         store data, right-justified (byte in [7:0], half in [15:0])
// rdata         output  32         extended load result, valid same cycle as mem_rd
// stall         output  1          1: hold MEM stage and all inputs stable next cycle
// acc_err       output  1          registered 1-cycle pulse: previous request was illegal
// dm_adr        output  32         word-aligned address to memory ({addr[ADDR_BITS-1:2],2'b00})
// dm_data_in    output  32         write data to memory
// dm_MemRead    output  1          memory read enable
// dm_MemWrite   output  1          memory write enable (memory writes at next posedge)
// dm_data_out   input   32         memory read data (combinational)
// BEHAVIOUR
// - States: IDLE, RMW_WR. Reset: state=IDLE, merge_q=0, acc_err=0. While rst=1 all combinational
//   outputs forced: stall=0, dm_MemRead=0, dm_MemWrite=0, rdata=0, dm_data_in=0.
// - Lane map (big-endian): byte k=addr[1:0] is dm_data_out[31-8k -: 8]; half at addr[1]=0 is
//   [31:16], at addr[1]=1 is [15:0].
// - Illegal request: mem_rd&mem_wr, size=11, or (CHECK_ALIGN and half with addr[0]=1 or word
//   with addr[1:0]!=0). Illegal -> no memory enable, stall=0, rdata=0, acc_err=1 next cycle.
// - IDLE, legal load: dm_MemRead=1, rdata = extended lane same cycle; stall=0; 0 extra latency.
// - IDLE, legal word store: dm_MemWrite=1, dm_data_in=wdata; stall=0; memory updated at posedge.
// - IDLE, legal byte/half store: dm_MemRead=1, stall=1; merge_q <= dm_data_out with the selected
//   lane replaced by wdata[7:0]/wdata[15:0]; state -> RMW_WR.
// - RMW_WR: dm_MemWrite=1, dm_data_in=merge_q, dm_adr from held addr, stall=0, state -> IDLE.
//   Request inputs ignored in RMW_WR (pipeline holds them stable).
// - rst asserted in RMW_WR: write aborted (dm_MemWrite=0 that cycle), state -> IDLE.
// - No request (mem_rd=mem_wr=0): all enables 0, rdata=0, stall=0.
// - Throughput: 1 access/cycle except sub-word store = 2 cycles; back-to-back RMW allowed.
// TESTING
// - mem[0..3]=8'h80,12,34,56; lb addr 0 -> rdata=32'hFFFF_FF80; lbu addr 0 -> 32'h0000_0080.
// - Same memory: lh addr 2 -> 32'h0000_3456; lw addr 0 -> 32'h8012_3456, stall=0 throughout.
// - sb addr 1, wdata=32'h0000_00AB -> stall=1 cycle, then write 32'h80AB_3456; lw addr 0 confirms.
// - sh addr 2, wdata 32'hBEEF then sb addr 0 back-to-back -> words 32'h8012_BEEF then
//   32'hXX12_BEEF with XX=wdata[7:0]; 2 stall cycles total, never overlapping enables.
// - lw addr 2 (CHECK_ALIGN=1) -> no dm_MemRead, rdata=0, acc_err=1 next cycle only; same for
//   mem_rd=mem_wr=1 and size=11.
// - sb issued, rst=1 in RMW_WR cycle -> dm_MemWrite stays 0, memory unchanged, state IDLE.

Source files
------------

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: aligned word port, load extension,
// sub-word stores via two-cycle read-modify-write.
module dmem_access_unit #(
  parameter int ADDR_BITS   = 12,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        acc_err,
  output logic [31:0] dm_adr,
  output logic [31:0] dm_data_in,
  output logic        dm_MemRead,
  output logic        dm_MemWrite,
  input  logic [31:0] dm_data_out
);

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic        err_q, err_d;

  logic        req;
  logic        illegal;
  logic        misalign;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;
  logic [31:0] st_merge;
  logic        unused_addr;

  assign unused_addr = ^addr[31:ADDR_BITS];

  assign dm_adr = {{(32-ADDR_BITS){1'b0}},
                   addr[ADDR_BITS-1:2], 2'b00};

  assign req = mem_rd | mem_wr;

  assign misalign =
    ((size == 2'b01) && addr[0]) ||
    ((size == 2'b10) && (addr[1:0] != 2'b00));

  assign illegal = (mem_rd & mem_wr) ||
                   (size == 2'b11) ||
                   (CHECK_ALIGN && misalign);

  assign acc_err = err_q;

  // Big-endian lane pick: byte 0 is the most significant byte.
  always_comb begin
    lane_b = dm_data_out[31:24];
    unique case (addr[1:0])
      2'd0: lane_b = dm_data_out[31:24];
      2'd1: lane_b = dm_data_out[23:16];
      2'd2: lane_b = dm_data_out[15:8];
      2'd3: lane_b = dm_data_out[7:0];
      default: lane_b = dm_data_out[31:24];
    endcase
    lane_h = addr[1] ? dm_data_out[15:0]
                     : dm_data_out[31:16];
  end

  // Load extension by size and signedness.
  always_comb begin
    ld_val = dm_data_out;
    unique case (size)
      2'b00: ld_val = {{24{~ld_unsigned & lane_b[7]}},
                       lane_b};
      2'b01: ld_val = {{16{~ld_unsigned & lane_h[15]}},
                       lane_h};
      default: ld_val = dm_data_out;
    endcase
  end

  // Merge store data into the word read back from memory.
  always_comb begin
    st_merge = dm_data_out;
    if (size == 2'b00) begin
      unique case (addr[1:0])
        2'd0: st_merge[31:24] = wdata[7:0];
        2'd1: st_merge[23:16] = wdata[7:0];
        2'd2: st_merge[15:8]  = wdata[7:0];
        2'd3: st_merge[7:0]   = wdata[7:0];
        default: st_merge = dm_data_out;
      endcase
    end else if (addr[1]) begin
      st_merge[15:0] = wdata[15:0];
    end else begin
      st_merge[31:16] = wdata[15:0];
    end
  end

  // Next state and memory-side controls; reset forces everything quiet.
  always_comb begin
    state_d     = state_q;
    merge_d     = merge_q;
    err_d       = 1'b0;
    stall       = 1'b0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    rdata       = 32'h0;
    dm_data_in  = 32'h0;
    if (rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              err_d = 1'b1;
            end else if (mem_rd) begin
              dm_MemRead = 1'b1;
              rdata      = ld_val;
            end else if (size == 2'b10) begin
              dm_MemWrite = 1'b1;
              dm_data_in  = wdata;
            end else begin
              dm_MemRead = 1'b1;
              stall      = 1'b1;
              merge_d    = st_merge;
              state_d    = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          dm_MemWrite = 1'b1;
          dm_data_in  = merge_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, merge buffer and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      merge_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: byte memory model, expected-event
// queue filled by the stimulus, drained by a negedge monitor.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, dm_adr, dm_data_in, dm_data_out;
  logic        stall, acc_err, dm_MemRead, dm_MemWrite;

  logic [7:0]  mem [64];
  logic        load_mem;
  logic [5:0]  ma;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          err;
    bit          stl;
    bit          chk_rdata;
    logic [31:0] adr;
    logic [31:0] rdat;
    logic [31:0] din;
  } ev_t;

  ev_t exp_q[$];

  dmem_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .size(size), .ld_unsigned(ld_unsigned),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .acc_err(acc_err),
    .dm_adr(dm_adr), .dm_data_in(dm_data_in),
    .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
    .dm_data_out(dm_data_out)
  );

  always #5 clk = ~clk;

  assign ma = dm_adr[5:0];
  assign dm_data_out = {mem[ma], mem[ma + 6'd1],
                        mem[ma + 6'd2], mem[ma + 6'd3]};

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h80;
      mem[1] <= 8'h12;
      mem[2] <= 8'h34;
      mem[3] <= 8'h56;
    end else if (dm_MemWrite) begin
      mem[ma]        <= dm_data_in[31:24];
      mem[ma + 6'd1] <= dm_data_in[23:16];
      mem[ma + 6'd2] <= dm_data_in[15:8];
      mem[ma + 6'd3] <= dm_data_in[7:0];
    end
  end

  always @(negedge clk) begin
    if (dm_MemRead || dm_MemWrite || acc_err || stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event rd=%0b wr=%0b err=%0b stall=%0b adr=%h",
                 dm_MemRead, dm_MemWrite, acc_err, stall, dm_adr);
      end else begin
        ev_t e;
        bit ok;
        e = exp_q.pop_front();
        ok = (dm_MemRead == e.rd) && (dm_MemWrite == e.wr) &&
             (acc_err == e.err) && (stall == e.stl) &&
             (dm_adr == e.adr);
        if (e.chk_rdata && rdata != e.rdat) ok = 0;
        if (e.wr && dm_data_in != e.din) ok = 0;
        if (!ok)
          begin
            errors++;
            $display("FAIL event got rd%0b wr%0b err%0b st%0b adr=%h rdata=%h din=%h need rd%0b wr%0b err%0b st%0b adr=%h rdata=%h din=%h",
                     dm_MemRead, dm_MemWrite, acc_err, stall, dm_adr,
                     rdata, dm_data_in, e.rd, e.wr, e.err, e.stl,
                     e.adr, e.rdat, e.din);
          end
      end
    end
  end

  function automatic void exp_rd(logic [31:0] a, logic [31:0] d,
                                 bit chk, bit st);
    ev_t e;
    e = '{rd: 1, wr: 0, err: 0, stl: st, chk_rdata: chk,
          adr: a, rdat: d, din: 32'h0};
    exp_q.push_back(e);
  endfunction

  function automatic void exp_wr(logic [31:0] a, logic [31:0] d);
    ev_t e;
    e = '{rd: 0, wr: 1, err: 0, stl: 0, chk_rdata: 0,
          adr: a, rdat: 32'h0, din: d};
    exp_q.push_back(e);
  endfunction

  function automatic void exp_err();
    ev_t e;
    e = '{rd: 0, wr: 0, err: 1, stl: 0, chk_rdata: 1,
          adr: 32'h0, rdat: 32'h0, din: 32'h0};
    exp_q.push_back(e);
  endfunction

  task automatic issue(input bit rd, input bit wr,
                       input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int n);
    mem_rd = rd; mem_wr = wr; size = sz;
    ld_unsigned = uns; addr = a; wdata = wd;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue(0, 0, 2'b00, 0, 32'h0, 32'h0, 1);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%h need=%h", name, got, need);
    end
  endtask

  initial begin
    rst = 1'b1;
    load_mem = 1'b1;
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    load_mem = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_enables", {30'h0, dm_MemRead, dm_MemWrite}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    issue(1, 1, 2'b10, 0, 32'h0, 32'h0, 1);
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_acc_err", {31'h0, acc_err}, 32'h0);
    @(posedge clk); #1;

    exp_rd(32'h0, 32'hFFFF_FF80, 1, 0);
    issue(1, 0, 2'b00, 0, 32'h0, 32'h0, 1);
    exp_rd(32'h0, 32'h0000_0080, 1, 0);
    issue(1, 0, 2'b00, 1, 32'h0, 32'h0, 1);
    exp_rd(32'h0, 32'h0000_3456, 1, 0);
    issue(1, 0, 2'b01, 0, 32'h2, 32'h0, 1);
    exp_rd(32'h0, 32'h8012_3456, 1, 0);
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 1);

    exp_rd(32'h0, 32'h0, 0, 1);
    exp_wr(32'h0, 32'h80AB_3456);
    issue(0, 1, 2'b00, 0, 32'h1, 32'h0000_00AB, 2);
    exp_rd(32'h0, 32'h80AB_3456, 1, 0);
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 1);

    exp_rd(32'h0, 32'h0, 0, 1);
    exp_wr(32'h0, 32'h80AB_BEEF);
    issue(0, 1, 2'b01, 0, 32'h2, 32'h0000_BEEF, 2);
    exp_rd(32'h0, 32'h0, 0, 1);
    exp_wr(32'h0, 32'hC5AB_BEEF);
    issue(0, 1, 2'b00, 0, 32'h0, 32'h1234_56C5, 2);
    exp_rd(32'h0, 32'hC5AB_BEEF, 1, 0);
    issue(1, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    exp_rd(32'h0, 32'hFFFF_FFEF, 1, 0);
    issue(1, 0, 2'b00, 0, 32'h3, 32'h0, 1);
    exp_rd(32'h0, 32'hFFFF_C5AB, 1, 0);
    issue(1, 0, 2'b01, 0, 32'h0, 32'h0, 1);
    exp_rd(32'h0, 32'h0000_C5AB, 1, 0);
    issue(1, 0, 2'b01, 1, 32'h0, 32'h0, 1);
    exp_rd(32'h0, 32'h0000_00AB, 1, 0);
    issue(1, 0, 2'b00, 1, 32'h1, 32'h0, 1);

    exp_wr(32'h4, 32'h1122_3344);
    issue(0, 1, 2'b10, 0, 32'h4, 32'h1122_3344, 1);
    exp_rd(32'h4, 32'h1122_3344, 1, 0);
    issue(1, 0, 2'b10, 0, 32'h4, 32'h0, 1);
    exp_rd(32'h4, 32'h0000_0044, 1, 0);
    issue(1, 0, 2'b00, 0, 32'h7, 32'h0, 1);
    exp_rd(32'h4, 32'h0000_3344, 1, 0);
    issue(1, 0, 2'b01, 0, 32'h6, 32'h0, 1);

    issue(1, 0, 2'b10, 0, 32'h2, 32'h0, 1);
    exp_err();
    idle();
    idle();
    issue(1, 1, 2'b10, 0, 32'h0, 32'h0, 1);
    exp_err();
    idle();
    issue(1, 0, 2'b11, 0, 32'h0, 32'h0, 1);
    exp_err();
    idle();
    issue(0, 1, 2'b01, 0, 32'h5, 32'h0000_DEAD, 1);
    exp_err();
    idle();
    issue(0, 1, 2'b10, 0, 32'h6, 32'hDEAD_BEEF, 1);
    exp_err();
    idle();
    idle();

    exp_rd(32'h4, 32'h0, 0, 1);
    issue(0, 1, 2'b00, 0, 32'h4, 32'h0000_0099, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_write", {31'h0, dm_MemWrite}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    exp_rd(32'h4, 32'h1122_3344, 1, 0);
    issue(1, 0, 2'b10, 0, 32'h4, 32'h0, 1);
    idle();
    idle();

    chk("mem_w0", {mem[0], mem[1], mem[2], mem[3]}, 32'hC5AB_BEEF);
    chk("mem_w1", {mem[4], mem[5], mem[6], mem[7]}, 32'h1122_3344);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
